// File: rtl/bht_update_ctrl.sv
// ---------------------------------------------------------------------------
// bht_update_ctrl
//
// Training-side companion to the branch history table. Every conditional
// branch predicted at fetch is recorded (PC + predicted direction) in a small
// in-order queue. When execute resolves the oldest in-flight branch, the
// recorded prediction is compared with the real outcome. The block then:
//   - drives the BHT write port (PC_update, BR, update),
//   - raises a registered mispredict strobe with the correct next PC,
//   - keeps saturating statistics on resolved and mispredicted branches.
//
// Ports:
//   clk, rst        : clock (posedge) and asynchronous active-high reset
//   pred_valid      : fetch issued a conditional branch this cycle
//   pred_pc         : PC of that branch
//   pred_br         : direction the BHT predicted (1 = taken)
//   pred_ready      : queue has room (combinational, equals !full)
//   res_valid       : oldest in-flight branch resolved this cycle
//   res_br          : actual direction (1 = taken)
//   res_target      : actual taken target
//   flush           : external squash, clears every in-flight entry
//   PC_update       : PC of the resolved branch (to BHT)
//   BR              : actual outcome (to BHT)
//   update          : one-cycle BHT write strobe
//   mispredict      : one-cycle redirect strobe
//   redirect_pc     : correct next PC while mispredict is high
//   count           : number of entries in flight
//   branch_cnt      : resolved branches since reset (saturating)
//   mispredict_cnt  : mispredictions since reset (saturating)
// ---------------------------------------------------------------------------
module bht_update_ctrl #(
  parameter int PTR_W = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic [31:0]      pred_pc,
  input  logic             pred_br,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_br,
  input  logic [31:0]      res_target,
  input  logic             flush,
  output logic [31:0]      PC_update,
  output logic             BR,
  output logic             update,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [PTR_W:0]   count,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int DEPTH = 1 << PTR_W;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  // Queue storage and bookkeeping
  logic [31:0]      r_pcMem [DEPTH];
  logic             r_brMem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  // Registered outputs toward BHT / front end
  logic [31:0]      r_pcUpdate;
  logic             r_br;
  logic             r_update;
  logic             r_mispredict;
  logic [31:0]      r_redirectPc;
  logic [CNT_W-1:0] r_branchCnt;
  logic [CNT_W-1:0] r_mispredictCnt;

  // Combinational decisions for this cycle
  logic             w_full;
  logic             w_empty;
  logic [31:0]      w_headPc;
  logic             w_headBr;
  logic             w_doResolve;
  logic             w_doMispredict;
  logic             w_doPush;
  logic             w_squash;
  logic [31:0]      w_redirectPc;

  // Decode what happens at the next edge. flush dominates everything; a
  // detected mispredict wipes the queue, so a same-cycle push is dropped too.
  // A push arriving while the queue is empty cannot be resolved in the same
  // cycle because resolution only looks at entries already stored.
  always_comb begin
    w_full         = (r_count == DEPTH_CNT);
    w_empty        = (r_count == '0);
    w_headPc       = r_pcMem[r_head];
    w_headBr       = r_brMem[r_head];
    w_doResolve    = res_valid && !w_empty && !flush;
    w_doMispredict = w_doResolve && (res_br != w_headBr);
    w_squash       = flush || w_doMispredict;
    w_doPush       = pred_valid && !w_full && !w_squash;
    w_redirectPc   = res_br ? res_target : (w_headPc + 32'd4);
  end

  // Entry storage carries no reset: validity is tracked purely by the
  // pointers and count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_pcMem[r_tail] <= pred_pc;
      r_brMem[r_tail] <= pred_br;
    end
  end

  // Pointer and occupancy tracking. A squash collapses the queue by pulling
  // head up to tail; tail itself does not move because the push was dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_squash) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_doResolve) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_doPush, w_doResolve})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // BHT update and redirect. The strobes pulse for exactly the cycle after a
  // resolve; the data fields keep their last value between pulses so the
  // BHT and front end may sample them lazily.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcUpdate   <= '0;
      r_br         <= 1'b0;
      r_update     <= 1'b0;
      r_mispredict <= 1'b0;
      r_redirectPc <= '0;
    end else begin
      r_update     <= w_doResolve;
      r_mispredict <= w_doMispredict;
      if (w_doResolve) begin
        r_pcUpdate   <= w_headPc;
        r_br         <= res_br;
        r_redirectPc <= w_redirectPc;
      end
    end
  end

  // Statistics counters stick at all-ones rather than wrapping, so long
  // runs never report a misleadingly small total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branchCnt     <= '0;
      r_mispredictCnt <= '0;
    end else begin
      if (w_doResolve && (r_branchCnt != '1)) begin
        r_branchCnt <= r_branchCnt + 1'b1;
      end
      if (w_doMispredict && (r_mispredictCnt != '1)) begin
        r_mispredictCnt <= r_mispredictCnt + 1'b1;
      end
    end
  end

  assign pred_ready     = !w_full;
  assign PC_update      = r_pcUpdate;
  assign BR             = r_br;
  assign update         = r_update;
  assign mispredict     = r_mispredict;
  assign redirect_pc    = r_redirectPc;
  assign count          = r_count;
  assign branch_cnt     = r_branchCnt;
  assign mispredict_cnt = r_mispredictCnt;

endmodule

// File: doc/bht_update_ctrl.md
Name: bht_update_ctrl

Overview:
- Training-side companion to the branch history table. Records every fetch-time prediction (PC, predicted direction) in an in-order queue.
- When the execute stage resolves the oldest branch, it compares the actual outcome against the recorded prediction.
- It then drives the BHT update port (PC_update, BR, update) and raises a registered mispredict/redirect to the front end.
- It also keeps branch and mispredict statistics counters.

Parameters:
- PTR_W, 2, queue pointer width; queue depth DEPTH = 1 << PTR_W (default 4 entries).
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- pred_valid  input  1  fetch stage issued a conditional branch this cycle.
- pred_pc  input  32  PC of that branch.
- pred_br  input  1  direction predicted by the BHT (1 = taken).
- pred_ready  output  1  queue can accept; equals !full, combinational from state.
- res_valid  input  1  oldest in-flight branch resolved this cycle.
- res_br  input  1  actual direction (1 = taken).
- res_target  input  32  actual taken target.
- flush  input  1  external squash (exception/interrupt); clears all in-flight entries.
- PC_update  output  32  PC of the resolved branch, to BHT.
- BR  output  1  actual outcome, to BHT.
- update  output  1  one-cycle BHT write strobe.
- mispredict  output  1  one-cycle redirect strobe.
- redirect_pc  output  32  correct next PC when mispredict = 1.
- count  output  PTR_W+1  entries currently in flight.
- branch_cnt  output  CNT_W  resolved branches since reset.
- mispredict_cnt  output  CNT_W  mispredictions since reset.

Behaviour:
- Reset (async, rst=1):
  - Queue empty; head, tail and count = 0.
  - update, mispredict, BR = 0; PC_update and redirect_pc = 0.
  - Both statistics counters = 0.
  - Reset mid-operation discards all entries immediately.
- Push:
  - pred_valid && pred_ready at posedge writes {pred_pc, pred_br} at tail; tail wraps modulo DEPTH.
  - pred_valid while full is dropped; the front end must stall on pred_ready = 0.
- Resolve: res_valid && count != 0 at posedge pops the head entry and, on that same edge, registers:
  - PC_update = head pc; BR = res_br; update = 1.
  - mispredict = (res_br != head pred_br).
  - redirect_pc = res_target if res_br, else head pc + 4 (32-bit wrap).
  - branch_cnt += 1; mispredict_cnt += 1 if mispredict.
  - Both counters saturate at all-ones.
- Latency: outputs are visible exactly one cycle after the res_valid cycle. update and mispredict are single-cycle pulses, otherwise 0.
- res_valid with count == 0 is ignored: no pop, no update, counters unchanged. A push in that same cycle does not count as resolvable.
- Mispredict squash:
  - On the resolving edge that detects a mispredict, all younger entries are discarded (head = tail, count = 0).
  - Any push in that same cycle is also discarded.
- Simultaneous push and resolve without mispredict: both occur; count unchanged.
  - When full, pred_ready = 0, so no push occurs even if a pop happens that cycle.
- flush has the highest priority:
  - Queue cleared; same-cycle push discarded.
  - Same-cycle res_valid ignored: no update, no mispredict, counters unchanged.
  - update and mispredict are 0 on the following cycle.
- Counters are never cleared except by rst.
- PC_update, BR and redirect_pc hold their last values between pulses.

Test Plan:
- Reset then idle: assert rst mid-run -> count=0, pred_ready=1, update=0, mispredict=0, branch_cnt=0.
- Correct prediction: push pc=0x100 pred_br=1; next cycle res_valid, res_br=1, res_target=0x200 -> one cycle later update=1, PC_update=0x100, BR=1, mispredict=0, branch_cnt=1, count=0.
- Not-taken mispredict with squash:
  - Stimulus: push 0x100(pred 1), 0x104(pred 0), 0x108(pred 1); resolve head with res_br=0.
  - Response: mispredict=1, redirect_pc=0x104, BR=0, count=0 after the edge, mispredict_cnt=1.
  - Subsequent res_valid is ignored.
- Full queue: push 4 entries -> pred_ready=0; a 5th pred_valid is dropped. Resolve all 4 correctly -> four update pulses with PCs in push order, branch_cnt=4.
- Simultaneous push and resolve at count=2 with correct prediction -> count stays 2; the popped PC appears on PC_update next cycle.
- flush coinciding with res_valid and pred_valid -> count=0, update=0, mispredict=0, counters unchanged. res_valid on the empty queue afterwards -> no update.
